// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the two-port memory arbiter.
//   - arb_state_e : sequencer states (IDLE, ACCESS, WAIT, DONE)
//   - port_sel_e  : requester select (PORT_A, PORT_B)
//   - AW_DEF / DW_DEF : default memory address / data widths
//   - CNT_W       : width of the optional completed-access counters
//   - sat_inc     : saturating increment used by those counters
package mem_arb_pkg;

  localparam int AW_DEF = 5;
  localparam int DW_DEF = 8;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } arb_state_e;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_sel_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == {CNT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// mem_arb_rr: 2-way round-robin picker.
// Ports:
//   req_a, req_b  in  : pending requests
//   last_grant    in  : port that won the previous arbitration
//   grant_valid   out : at least one request is pending
//   grant_sel     out : winning port; on a tie the port that did not win last
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic      req_a,
  input  logic      req_b,
  input  port_sel_e last_grant,
  output logic      grant_valid,
  output port_sel_e grant_sel
);

  // Pick the winner; a tie goes to the port that was not granted last time.
  always_comb begin
    grant_valid = req_a | req_b;
    grant_sel   = PORT_A;
    if (req_a && req_b) begin
      grant_sel = (last_grant == PORT_A) ? PORT_B : PORT_A;
    end else if (req_b) begin
      grant_sel = PORT_B;
    end else begin
      grant_sel = PORT_A;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter and sequencer for a shared synchronous
// memory with two requesters (A and B).
// Ports:
//   clock, resetn                : clock (rising edge), async active-low reset
//   {a,b}_req/_we/_addr/_wdata   : request, held stable until the matching ack
//   {a,b}_ack                    : one-cycle completion pulse
//   {a,b}_rdata / {a,b}_err      : read data and "mem_valid low at sample" flag,
//                                  valid with ack on reads, held otherwise
//   mem_address/mem_data/mem_wren: to memory; wren high only in ACCESS
//   mem_q / mem_valid            : from memory
//   busy                         : FSM not in IDLE
//   grant_cnt_a / grant_cnt_b    : completed-access counters
// Optional feature macro: MEM_ARB_STATS_EN enables the saturating counters;
// without it both counter outputs are constant zero.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW           = AW_DEF,
  parameter int DW           = DW_DEF,
  parameter int READ_LATENCY = 1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             a_req,
  input  logic             a_we,
  input  logic [AW-1:0]    a_addr,
  input  logic [DW-1:0]    a_wdata,
  output logic             a_ack,
  output logic [DW-1:0]    a_rdata,
  output logic             a_err,
  input  logic             b_req,
  input  logic             b_we,
  input  logic [AW-1:0]    b_addr,
  input  logic [DW-1:0]    b_wdata,
  output logic             b_ack,
  output logic [DW-1:0]    b_rdata,
  output logic             b_err,
  output logic [AW-1:0]    mem_address,
  output logic [DW-1:0]    mem_data,
  output logic             mem_wren,
  input  logic [DW-1:0]    mem_q,
  input  logic             mem_valid,
  output logic             busy,
  output logic [CNT_W-1:0] grant_cnt_a,
  output logic [CNT_W-1:0] grant_cnt_b
);

  // WAIT lasts READ_LATENCY cycles: the counter is loaded with LAT-1 and
  // mem_q is sampled on the cycle it reads zero.
  localparam logic [1:0] LAT_LOAD = 2'(READ_LATENCY - 1);

  arb_state_e    state_q, state_d;
  port_sel_e     last_grant_q, last_grant_d;
  port_sel_e     sel_q, sel_d;
  logic          we_q, we_d;
  logic [1:0]    lat_cnt_q, lat_cnt_d;
  // mem_address_q / mem_data_q double as the latched request address/data.
  logic [AW-1:0] mem_address_q, mem_address_d;
  logic [DW-1:0] mem_data_q, mem_data_d;
  logic          mem_wren_q, mem_wren_d;
  logic          a_ack_q, a_ack_d;
  logic          b_ack_q, b_ack_d;
  logic [DW-1:0] a_rdata_q, a_rdata_d;
  logic [DW-1:0] b_rdata_q, b_rdata_d;
  logic          a_err_q, a_err_d;
  logic          b_err_q, b_err_d;
  logic          busy_q, busy_d;

  logic          grant_valid_s;
  port_sel_e     grant_sel_s;
  logic          done_entry_s;

  mem_arb_rr u_rr (
    .req_a       (a_req),
    .req_b       (b_req),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid_s),
    .grant_sel   (grant_sel_s)
  );

  // Next-state and next-output logic of the access sequencer.
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    sel_d         = sel_q;
    we_d          = we_q;
    lat_cnt_d     = lat_cnt_q;
    mem_address_d = mem_address_q;
    mem_data_d    = mem_data_q;
    mem_wren_d    = 1'b0;
    a_rdata_d     = a_rdata_q;
    b_rdata_d     = b_rdata_q;
    a_err_d       = a_err_q;
    b_err_d       = b_err_q;
    done_entry_s  = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_valid_s) begin
          sel_d        = grant_sel_s;
          last_grant_d = grant_sel_s;
          if (grant_sel_s == PORT_B) begin
            we_d          = b_we;
            mem_address_d = b_addr;
            mem_data_d    = b_wdata;
            mem_wren_d    = b_we;
          end else begin
            we_d          = a_we;
            mem_address_d = a_addr;
            mem_data_d    = a_wdata;
            mem_wren_d    = a_we;
          end
          state_d = ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (we_q) begin
          state_d      = DONE;
          done_entry_s = 1'b1;
        end else begin
          state_d   = WAIT;
          lat_cnt_d = LAT_LOAD;
        end
      end
      WAIT: begin
        if (lat_cnt_q == 2'd0) begin
          if (sel_q == PORT_B) begin
            b_rdata_d = mem_q;
            b_err_d   = ~mem_valid;
          end else begin
            a_rdata_d = mem_q;
            a_err_d   = ~mem_valid;
          end
          state_d      = DONE;
          done_entry_s = 1'b1;
        end else begin
          lat_cnt_d = lat_cnt_q - 2'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Ack is raised as DONE is entered so it is visible for the DONE cycle.
    a_ack_d = done_entry_s & (sel_q == PORT_A);
    b_ack_d = done_entry_s & (sel_q == PORT_B);
    busy_d  = (state_d != IDLE);
  end

  // State and registered outputs; reset aborts any access in flight.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      last_grant_q  <= PORT_B;
      sel_q         <= PORT_A;
      we_q          <= 1'b0;
      lat_cnt_q     <= 2'd0;
      mem_address_q <= {AW{1'b0}};
      mem_data_q    <= {DW{1'b0}};
      mem_wren_q    <= 1'b0;
      a_ack_q       <= 1'b0;
      b_ack_q       <= 1'b0;
      a_rdata_q     <= {DW{1'b0}};
      b_rdata_q     <= {DW{1'b0}};
      a_err_q       <= 1'b0;
      b_err_q       <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      sel_q         <= sel_d;
      we_q          <= we_d;
      lat_cnt_q     <= lat_cnt_d;
      mem_address_q <= mem_address_d;
      mem_data_q    <= mem_data_d;
      mem_wren_q    <= mem_wren_d;
      a_ack_q       <= a_ack_d;
      b_ack_q       <= b_ack_d;
      a_rdata_q     <= a_rdata_d;
      b_rdata_q     <= b_rdata_d;
      a_err_q       <= a_err_d;
      b_err_q       <= b_err_d;
      busy_q        <= busy_d;
    end
  end

  assign mem_address = mem_address_q;
  assign mem_data    = mem_data_q;
  assign mem_wren    = mem_wren_q;
  assign a_ack       = a_ack_q;
  assign b_ack       = b_ack_q;
  assign a_rdata     = a_rdata_q;
  assign b_rdata     = b_rdata_q;
  assign a_err       = a_err_q;
  assign b_err       = b_err_q;
  assign busy        = busy_q;

`ifdef MEM_ARB_STATS_EN
  logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
  logic [CNT_W-1:0] cnt_b_q, cnt_b_d;

  // Counters step together with the ack they count.
  always_comb begin
    cnt_a_d = a_ack_d ? sat_inc(cnt_a_q) : cnt_a_q;
    cnt_b_d = b_ack_d ? sat_inc(cnt_b_q) : cnt_b_q;
  end

  // Completed-access counter registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_a_q <= {CNT_W{1'b0}};
      cnt_b_q <= {CNT_W{1'b0}};
    end else begin
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
    end
  end

  assign grant_cnt_a = cnt_a_q;
  assign grant_cnt_b = cnt_b_q;
`else
  assign grant_cnt_a = {CNT_W{1'b0}};
  assign grant_cnt_b = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter.
// A 32x8 synchronous memory model sits on the memory side. A transaction-level
// reference model predicts every output each cycle: it tracks which access is
// in flight and how many cycles it has left (2 for writes, 3 for reads),
// applies the tie-break rule and keeps its own copy of the memory contents.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 5;
  localparam int DW = 8;
  localparam int RL = 1;
`ifdef MEM_ARB_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  typedef struct {
    bit          we;
    logic [4:0]  addr;
    logic [7:0]  wdata;
  } tx_t;

  logic          clock = 1'b0;
  logic          resetn = 1'b1;
  logic          a_req = 1'b0, a_we = 1'b0;
  logic [AW-1:0] a_addr = '0;
  logic [DW-1:0] a_wdata = '0;
  logic          b_req = 1'b0, b_we = 1'b0;
  logic [AW-1:0] b_addr = '0;
  logic [DW-1:0] b_wdata = '0;
  logic          a_ack, b_ack, a_err, b_err, mem_wren, busy;
  logic [DW-1:0] a_rdata, b_rdata, mem_data;
  logic [DW-1:0] mem_q;
  logic          mem_valid = 1'b1;
  logic [AW-1:0] mem_address;
  logic [15:0]   grant_cnt_a, grant_cnt_b;

  mem_arbiter #(.AW(AW), .DW(DW), .READ_LATENCY(RL)) dut (
    .clock(clock), .resetn(resetn),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata), .b_err(b_err),
    .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren),
    .mem_q(mem_q), .mem_valid(mem_valid), .busy(busy),
    .grant_cnt_a(grant_cnt_a), .grant_cnt_b(grant_cnt_b)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] init_val(input int i);
    return 8'(i * 37 + 11);
  endfunction

  // Synchronous memory: write on wren, registered read of the presented address.
  logic [7:0] env_mem [32];
  bit env_init = 1'b0;
  always @(posedge clock) begin
    if (!env_init) begin
      for (int i = 0; i < 32; i++) env_mem[i] <= init_val(i);
      env_init <= 1'b1;
    end else if (mem_wren) begin
      env_mem[mem_address] <= mem_data;
    end
    mem_q <= env_mem[mem_address];
  end

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] ref_mem [32];
  int   m_k;          // -1 idle, else cycles since grant
  int   m_dur;        // 2 for write, 3 for read
  bit   m_port;       // 0 = A, 1 = B
  bit   m_last;       // last granted port
  bit   m_we;
  logic [4:0] m_addr;
  logic [7:0] m_wdata;
  int   m_cnt_a, m_cnt_b;
  logic       e_a_ack, e_b_ack, e_a_err, e_b_err, e_wren, e_busy;
  logic [7:0] e_a_rdata, e_b_rdata, e_data;
  logic [4:0] e_addr;

  tx_t txq_a[$];
  tx_t txq_b[$];
  int  obs_log[$];
  int  wren_cycles = 0;
  int  mv_mode = 0;   // 0: valid=1, 1: valid=0, 2: random

  function automatic logic [31:0] sat16(input int v);
    return (v > 65535) ? 32'd65535 : 32'(v);
  endfunction

  task automatic model_reset();
    m_k = -1; m_last = 1'b1; m_port = 1'b0; m_dur = 2;
    m_cnt_a = 0; m_cnt_b = 0;
    e_a_ack = 1'b0; e_b_ack = 1'b0; e_a_err = 1'b0; e_b_err = 1'b0;
    e_wren = 1'b0; e_busy = 1'b0; e_a_rdata = 8'h00; e_b_rdata = 8'h00;
    e_data = 8'h00; e_addr = 5'h00;
  endtask

  task automatic check_outputs();
    chk("a_ack", 32'(a_ack), 32'(e_a_ack));
    chk("b_ack", 32'(b_ack), 32'(e_b_ack));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("mem_wren", 32'(mem_wren), 32'(e_wren));
    chk("mem_address", 32'(mem_address), 32'(e_addr));
    chk("mem_data", 32'(mem_data), 32'(e_data));
    chk("a_rdata", 32'(a_rdata), 32'(e_a_rdata));
    chk("a_err", 32'(a_err), 32'(e_a_err));
    chk("b_rdata", 32'(b_rdata), 32'(e_b_rdata));
    chk("b_err", 32'(b_err), 32'(e_b_err));
    chk("grant_cnt_a", 32'(grant_cnt_a), STATS_ON ? sat16(m_cnt_a) : 32'd0);
    chk("grant_cnt_b", 32'(grant_cnt_b), STATS_ON ? sat16(m_cnt_b) : 32'd0);
    if (a_ack === 1'b1) obs_log.push_back(0);
    if (b_ack === 1'b1) obs_log.push_back(1);
    if (mem_wren === 1'b1) wren_cycles++;
  endtask

  // Requesters release on the (predicted) ack and take the next queued job.
  task automatic drive();
    tx_t t;
    if (e_a_ack) a_req = 1'b0;
    if (e_b_ack) b_req = 1'b0;
    if (!a_req && txq_a.size() > 0) begin
      t = txq_a.pop_front();
      a_req = 1'b1; a_we = t.we; a_addr = t.addr; a_wdata = t.wdata;
    end
    if (!b_req && txq_b.size() > 0) begin
      t = txq_b.pop_front();
      b_req = 1'b1; b_we = t.we; b_addr = t.addr; b_wdata = t.wdata;
    end
    case (mv_mode)
      0: mem_valid = 1'b1;
      1: mem_valid = 1'b0;
      default: mem_valid = ($urandom_range(0, 7) != 0);
    endcase
  endtask

  // Predict outputs after the coming rising edge from the current inputs.
  task automatic model_next();
    e_a_ack = 1'b0; e_b_ack = 1'b0; e_wren = 1'b0;
    if (m_k == -1) begin
      if (a_req || b_req) begin
        m_port = (a_req && b_req) ? ~m_last : b_req;
        m_last = m_port;
        m_we    = m_port ? b_we : a_we;
        m_addr  = m_port ? b_addr : a_addr;
        m_wdata = m_port ? b_wdata : a_wdata;
        m_dur   = m_we ? 2 : 3;
        m_k     = 0;
        e_wren  = m_we; e_addr = m_addr; e_data = m_wdata;
      end
    end else if (m_k == m_dur - 1) begin
      m_k = -1;
    end else begin
      if (m_k == 0 && m_we) ref_mem[m_addr] = m_wdata;
      m_k++;
    end
    if (m_k != -1 && m_k == m_dur - 1) begin
      if (m_port) begin
        e_b_ack = 1'b1; m_cnt_b++;
        if (!m_we) begin e_b_rdata = ref_mem[m_addr]; e_b_err = ~mem_valid; end
      end else begin
        e_a_ack = 1'b1; m_cnt_a++;
        if (!m_we) begin e_a_rdata = ref_mem[m_addr]; e_a_err = ~mem_valid; end
      end
    end
    e_busy = (m_k != -1);
  endtask

  task automatic step();
    @(negedge clock);
    check_outputs();
    drive();
    model_next();
  endtask

  // Async reset pulse: outputs must clear at once, then two cycles held.
  task automatic pulse_reset();
    resetn = 1'b0;
    model_reset();
    #1;
    check_outputs();
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    drive();
    model_next();
  endtask

  task automatic run_until_idle(input string tag, input int budget);
    int n = 0;
    while ((txq_a.size() > 0 || txq_b.size() > 0 || a_req || b_req || m_k != -1) && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_drain"}, 32'(n < budget), 32'd1);
  endtask

  function automatic tx_t mk(input bit we, input logic [4:0] addr, input logic [7:0] wd);
    tx_t t;
    t.we = we; t.addr = addr; t.wdata = wd;
    return t;
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) ref_mem[i] = init_val(i);
    model_reset();
    #2;
    pulse_reset();

    // 1: single A write
    wren_cycles = 0;
    txq_a.push_back(mk(1'b1, 5'h03, 8'hA5));
    run_until_idle("p1", 50);
    chk("p1_wren_cycles", 32'(wren_cycles), 32'd1);

    // 2: B writes 1F, A reads it back
    txq_b.push_back(mk(1'b1, 5'h1F, 8'h3C));
    run_until_idle("p2w", 50);
    txq_a.push_back(mk(1'b0, 5'h1F, 8'h77));
    run_until_idle("p2r", 50);
    chk("p2_a_rdata", 32'(a_rdata), 32'h3C);
    chk("p2_a_err", 32'(a_err), 32'd0);
    chk("p2_b_rdata", 32'(b_rdata), 32'h00);

    // 3: both ports busy from reset, 4 accesses each -> strict alternation
    pulse_reset();
    obs_log.delete();
    for (int i = 0; i < 4; i++) begin
      txq_a.push_back(mk(i[0], 5'(8 + i), 8'(8'h10 + i)));
      txq_b.push_back(mk(~i[0], 5'(16 + i), 8'(8'h20 + i)));
    end
    run_until_idle("p3", 200);
    chk("p3_ack_count", 32'(obs_log.size()), 32'd8);
    for (int i = 0; i < obs_log.size(); i++) chk("p3_ack_order", 32'(obs_log[i]), 32'(i % 2));

    // 4: read with mem_valid low at sample
    mv_mode = 1;
    txq_a.push_back(mk(1'b0, 5'h03, 8'h00));
    run_until_idle("p4", 50);
    chk("p4_a_err", 32'(a_err), 32'd1);
    chk("p4_a_rdata", 32'(a_rdata), 32'hA5);
    mv_mode = 0;

    // 5: reset during WAIT of a B read; A then wins the tie
    obs_log.delete();
    txq_b.push_back(mk(1'b0, 5'h1F, 8'h00));
    begin
      int n = 0;
      while (m_k != 1 && n < 20) begin step(); n++; end
      chk("p5_reach_wait", 32'(m_k), 32'd1);
    end
    step();
    txq_a.push_back(mk(1'b1, 5'h05, 8'h5A));
    pulse_reset();
    run_until_idle("p5", 50);
    chk("p5_ack_count", 32'(obs_log.size()), 32'd2);
    if (obs_log.size() == 2) begin
      chk("p5_first_ack", 32'(obs_log[0]), 32'd0);
      chk("p5_second_ack", 32'(obs_log[1]), 32'd1);
    end
    chk("p5_b_rdata", 32'(b_rdata), 32'h3C);

    // 6: counters after 3 A and 2 B completions
    pulse_reset();
    for (int i = 0; i < 3; i++) txq_a.push_back(mk(1'b1, 5'(i), 8'(i)));
    for (int i = 0; i < 2; i++) txq_b.push_back(mk(1'b0, 5'(i + 3), 8'h00));
    run_until_idle("p6", 100);
    chk("p6_cnt_a", 32'(grant_cnt_a), STATS_ON ? 32'd3 : 32'd0);
    chk("p6_cnt_b", 32'(grant_cnt_b), STATS_ON ? 32'd2 : 32'd0);

    // 7: random traffic with occasional resets
    mv_mode = 2;
    for (int c = 0; c < 1500; c++) begin
      if (txq_a.size() == 0 && $urandom_range(0, 3) == 0)
        txq_a.push_back(mk(1'($urandom), 5'($urandom), 8'($urandom)));
      if (txq_b.size() == 0 && $urandom_range(0, 3) == 0)
        txq_b.push_back(mk(1'($urandom), 5'($urandom), 8'($urandom)));
      if ($urandom_range(0, 299) == 0) pulse_reset();
      else step();
    end
    run_until_idle("p7", 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
